// File: rtl/aes_inv_sbox_arbiter.sv
// Shares one 32-bit inverse S-box between a 128-bit block requester (four sequential
// word lookups) and a single-word requester. `AES_ISBOX_BLK_PRIO_EN selects fixed block priority.
module aes_inv_sbox_arbiter #(
    parameter logic [31:0] IDLE_WORD = 32'h0000_0000,
    parameter bit          RR_INIT   = 1'b0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         blk_req,
    input  logic [127:0] blk_in,
    output logic         blk_ack,
    output logic [127:0] blk_out,
    input  logic         wrd_req,
    input  logic [31:0]  wrd_in,
    output logic         wrd_ack,
    output logic [31:0]  wrd_out,
    output logic [31:0]  isbox_word,
    input  logic [31:0]  isbox_new_word,
    output logic         busy
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_BLK  = 3'd1;
    localparam logic [2:0] ST_WRD  = 3'd2;
    localparam logic [2:0] ST_BACK = 3'd3;
    localparam logic [2:0] ST_WACK = 3'd4;

    logic [2:0]   state_reg, state_next;
    logic [1:0]   idx_reg;
    logic [127:0] blk_buf_reg;
    logic [31:0]  wrd_buf_reg;
    logic [95:0]  res_reg;
    logic [127:0] blk_out_reg;
    logic [31:0]  wrd_out_reg;
    logic         grant_blk;
    logic         grant_wrd;
    logic [31:0]  buf_word [0:3];

    // Word 0 is the most significant word of the captured block.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_buf_word
            assign buf_word[gi] = blk_buf_reg[127-32*gi -: 32];
        end
    endgenerate

`ifdef AES_ISBOX_BLK_PRIO_EN
    assign grant_blk = blk_req;
    assign grant_wrd = wrd_req && !blk_req;
`else
    logic rr_reg;

    // rr_reg == 0 favours the block requester on a tie; it then points at the loser.
    assign grant_blk = blk_req && (!wrd_req || !rr_reg);
    assign grant_wrd = wrd_req && (!blk_req || rr_reg);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_reg <= RR_INIT;
        end else if (state_reg == ST_IDLE) begin
            if (grant_blk) begin
                rr_reg <= 1'b1;
            end else if (grant_wrd) begin
                rr_reg <= 1'b0;
            end
        end
    end
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (grant_blk) begin
                    state_next = ST_BLK;
                end else if (grant_wrd) begin
                    state_next = ST_WRD;
                end
            end
            ST_BLK:  state_next = (idx_reg == 2'd3) ? ST_BACK : ST_BLK;
            ST_WRD:  state_next = ST_WACK;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        isbox_word = IDLE_WORD;
        case (state_reg)
            ST_BLK:  isbox_word = buf_word[idx_reg];
            ST_WRD:  isbox_word = wrd_buf_reg;
            default: isbox_word = IDLE_WORD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            idx_reg     <= 2'd0;
            blk_buf_reg <= '0;
            wrd_buf_reg <= '0;
            res_reg     <= '0;
            blk_out_reg <= '0;
            wrd_out_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    idx_reg <= 2'd0;
                    if (grant_blk) begin
                        blk_buf_reg <= blk_in;
                    end else if (grant_wrd) begin
                        wrd_buf_reg <= wrd_in;
                    end
                end
                ST_BLK: begin
                    idx_reg <= idx_reg + 2'd1;
                    // The last lookup lands directly in blk_out so it is valid during BACK.
                    case (idx_reg)
                        2'd0:    res_reg[95:64] <= isbox_new_word;
                        2'd1:    res_reg[63:32] <= isbox_new_word;
                        2'd2:    res_reg[31:0]  <= isbox_new_word;
                        default: blk_out_reg    <= {res_reg, isbox_new_word};
                    endcase
                end
                ST_WRD:  wrd_out_reg <= isbox_new_word;
                default: ;
            endcase
        end
    end

    assign blk_ack = (state_reg == ST_BACK);
    assign wrd_ack = (state_reg == ST_WACK);
    assign busy    = (state_reg != ST_IDLE);
    assign blk_out = blk_out_reg;
    assign wrd_out = wrd_out_reg;

endmodule

// File: doc/aes_inv_sbox_arbiter.md
Name: aes_inv_sbox_arbiter

Overview:
- Sequences and shares one external 32-bit inverse S-box (four parallel byte lookups) between two requesters.
- Block requester: full 128-bit InvSubBytes from the decipher datapath, done as four sequential 32-bit lookups.
- Word requester: single 32-bit lookup, e.g. key-schedule support.
- Sits between the decipher round logic and the single shared inverse S-box instance; saves three S-box copies per decipher core.

Parameters:
- IDLE_WORD, 32'h00000000, value driven on isbox_word when no lookup is in progress.
- RR_INIT, 0, round-robin pointer at reset: 0 = block requester wins the first tie, 1 = word requester wins it.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  synchronous, active-low reset.
- blk_req  input  1  block lookup request; held high until blk_ack.
- blk_in  input  128  block to substitute; sampled on the grant cycle only.
- blk_ack  output  1  one-cycle pulse: blk_out valid.
- blk_out  output  128  substituted block; held stable until the next block completion.
- wrd_req  input  1  word lookup request; held high until wrd_ack.
- wrd_in  input  32  word to substitute; sampled on the grant cycle only.
- wrd_ack  output  1  one-cycle pulse: wrd_out valid.
- wrd_out  output  32  substituted word; held stable until the next word completion.
- isbox_word  output  32  word presented to the shared inverse S-box.
- isbox_new_word  input  32  combinational S-box result for isbox_word.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Clock and reset: single clock clk; reset_n synchronous, active-low.
- Reset values: blk_ack=0, wrd_ack=0, blk_out=0, wrd_out=0, busy=0, isbox_word=IDLE_WORD, FSM=IDLE, word index=0, RR pointer=RR_INIT.
- FSM states: IDLE, BLK, WRD, BACK, WACK.
- IDLE:
  - One request high: grant it.
  - Both high: grant per RR pointer.
  - Grant to block: capture blk_in into an internal 128-bit buffer, index=0, go to BLK.
  - Grant to word: capture wrd_in, go to WRD.
  - RR pointer points to the loser after each grant.
- BLK:
  - isbox_word = buffer word[index]; index 0 = bits 127:96, 3 = bits 31:0.
  - isbox_new_word is written into result word[index] each cycle; index increments.
  - After index 3, go to BACK. Exactly 4 cycles; index never wraps inside one transaction.
- BACK: blk_ack=1 and blk_out = result for this cycle; go to IDLE.
- WRD: isbox_word = captured word; result registered; go to WACK.
- WACK: wrd_ack=1, wrd_out updated; go to IDLE.
- Latency from the req-sampled (grant) cycle N:
  - Block: ack in cycle N+5.
  - Word: ack in cycle N+2.
  - Back-to-back: a request pending in the cycle after an ack is granted that cycle. Block throughput is 1 per 6 cycles.
- Handshake:
  - Requester deasserts req in the cycle after seeing ack. If req is still high in IDLE, it is a new transaction.
  - req changes during BLK, WRD, BACK or WACK are ignored.
  - blk_in and wrd_in may change after grant.
- Idle output: isbox_word = IDLE_WORD in IDLE, BACK and WACK.
- Reset mid-operation: transaction aborted, no ack issued, all outputs return to reset values on the next edge.
- blk_ack and wrd_ack are never high in the same cycle.

Optional Feature:
- Macro: AES_ISBOX_BLK_PRIO_EN.
- Defined: fixed priority. Block requester always wins a tie; RR pointer and RR_INIT unused. A continuously asserted blk_req can starve wrd_req.
- Undefined (default): round-robin arbitration as described in Behaviour.

Test Plan:
- Reset: reset_n=0 for 2 cycles with both reqs high -> all outputs 0, isbox_word=IDLE_WORD, no acks. First grant after release follows RR_INIT.
- Block lookup: blk_in=128'h63636363_00000000_ffffffff_01020304 -> blk_ack exactly 5 cycles after grant, blk_out=128'h00000000_52525252_7d7d7d7d_096ad530. isbox_word steps through the four words in order 127:96 down to 31:0.
- Word lookup: wrd_in=32'h0063ff01 -> wrd_ack 2 cycles after grant, wrd_out=32'h52007d09, blk_out unchanged.
- Simultaneous requests held continuously, RR build: grants alternate block, word, block, word. With AES_ISBOX_BLK_PRIO_EN: block granted every time, wrd_ack never seen.
- Changing inputs: blk_in changed every cycle during BLK -> blk_out reflects only the value captured at grant. A req toggling mid-transaction causes no extra ack.
- Abort: reset_n=0 during BLK index 2 -> no blk_ack, blk_out=0. The next block request completes normally with the correct result.
